// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: NUM_REQ-way register-file write-port arbiter with a one-cycle registered write stage.
// Define WARB_ROUND_ROBIN_EN for round-robin priority; the default build uses fixed lowest-index priority.
module rf_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          hold,
  output logic                          rf_wen,
  output logic [ADDR_WIDTH-1:0]         rf_waddr,
  output logic [DATA_WIDTH-1:0]         rf_wdata,
  input  logic [ADDR_WIDTH-1:0]         pend_addr,
  output logic                          pend_hit
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      start_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  gvalid_s;
  logic [ADDR_WIDTH-1:0] gaddr_s;
  logic [DATA_WIDTH-1:0] gdata_s;

  logic                  wen_q,   wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

`ifdef WARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] gidx_s;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  assign start_s = ptr_q;
`else
  assign start_s = {PTR_W{1'b0}};
`endif

  // Grant search: pass 0 scans indices at/above the start point, pass 1 wraps to those below it.
  always_comb begin
    grant_s  = {NUM_REQ{1'b0}};
    gvalid_s = 1'b0;
    gaddr_s  = {ADDR_WIDTH{1'b0}};
    gdata_s  = {DATA_WIDTH{1'b0}};
`ifdef WARB_ROUND_ROBIN_EN
    gidx_s   = {PTR_W{1'b0}};
`endif
    if (rst_n && !hold) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!gvalid_s && req_valid[i] && ((p == 0) == (i >= int'(start_s)))) begin
            gvalid_s   = 1'b1;
            grant_s[i] = 1'b1;
            gaddr_s    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            gdata_s    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef WARB_ROUND_ROBIN_EN
            gidx_s     = PTR_W'(i);
`endif
          end else begin
            gvalid_s = gvalid_s;
          end
        end
      end
    end else begin
      grant_s = {NUM_REQ{1'b0}};
    end
  end

  assign req_ready = grant_s;

  // Write stage next state; address 0 is accepted but never written.
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gvalid_s) begin
      wen_d   = |gaddr_s;
      waddr_d = gaddr_s;
      wdata_d = gdata_s;
    end else begin
      wen_d   = 1'b0;
    end
  end

  // Write stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef WARB_ROUND_ROBIN_EN
  // Pointer advances past the winner so it has lowest priority next time.
  always_comb begin
    ptr_d = ptr_q;
    if (gvalid_s) begin
      if (gidx_s == PTR_W'(NUM_REQ - 1)) begin
        ptr_d = {PTR_W{1'b0}};
      end else begin
        ptr_d = gidx_s + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= {PTR_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign pend_hit = wen_q && (waddr_q == pend_addr) && (|pend_addr);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (NUM_REQ=2); expectations follow the build's priority mode.
module tb_rf_write_arbiter;

`ifdef WARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        hold;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  pend_addr;
  logic        pend_hit;

  int checks;
  int failures;

  rf_write_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_addr(pend_addr), .pend_hit(pend_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; pend_addr = 5'd3;
    set_req(2'b11, 5'd3, 5'd7, 32'h1, 32'h2);
    step(); step();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", rf_wen); end
    checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if (pend_hit !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", pend_hit); end
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_priority();
    logic [1:0] exp_g;
    set_req(2'b11, 5'd3, 5'd7, 32'h0000_1111, 32'h0000_2222);
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (RR && (k % 2 == 1)) ? 2'b10 : 2'b01;
      checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL prio_ready k=%0d got=%b exp=%b", k, req_ready, exp_g); end
      step();
      checks++; if (rf_wen !== 1'b1) begin failures++; $display("FAIL prio_wen k=%0d got=%b exp=1", k, rf_wen); end
      checks++; if (rf_waddr !== ((exp_g == 2'b01) ? 5'd3 : 5'd7)) begin failures++; $display("FAIL prio_waddr k=%0d got=%0d", k, rf_waddr); end
      checks++; if (rf_wdata !== ((exp_g == 2'b01) ? 32'h0000_1111 : 32'h0000_2222)) begin failures++; $display("FAIL prio_wdata k=%0d got=%h", k, rf_wdata); end
    end
  endtask

  task automatic test_addr_zero();
    set_req(2'b01, 5'd0, 5'd7, 32'h0000_DEAD, 32'h0);
    pend_addr = 5'd0;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL zero_ready got=%b exp=01", req_ready); end
    step();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL zero_wen got=%b exp=0", rf_wen); end
    checks++; if (rf_wdata !== 32'h0000_DEAD) begin failures++; $display("FAIL zero_wdata got=%h exp=dead", rf_wdata); end
    checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL zero_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (pend_hit !== 1'b0) begin failures++; $display("FAIL zero_pend got=%b exp=0", pend_hit); end
    req_valid = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL idle_ready got=%b exp=00", req_ready); end
    step();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL idle_wen got=%b exp=0", rf_wen); end
    checks++; if (rf_wdata !== 32'h0000_DEAD) begin failures++; $display("FAIL idle_wdata_hold got=%h exp=dead", rf_wdata); end
  endtask

  task automatic test_hold();
    set_req(2'b11, 5'd3, 5'd7, 32'h0000_00A3, 32'h0000_00A7);
    #1;
    checks++; if (req_ready !== (RR ? 2'b10 : 2'b01)) begin failures++; $display("FAIL hold_pre_ready got=%b", req_ready); end
    step();
    hold = 1'b1;
    #1;
    checks++; if (rf_wen !== 1'b1) begin failures++; $display("FAIL hold_inflight_wen got=%b exp=1", rf_wen); end
    checks++; if (rf_waddr !== (RR ? 5'd7 : 5'd3)) begin failures++; $display("FAIL hold_inflight_waddr got=%0d", rf_waddr); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL hold_ready got=%b exp=00", req_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL hold_wen k=%0d got=%b exp=0", k, rf_wen); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL hold_ready k=%0d got=%b exp=00", k, req_ready); end
    end
    checks++; if (rf_waddr !== (RR ? 5'd7 : 5'd3)) begin failures++; $display("FAIL hold_waddr_keep got=%0d", rf_waddr); end
    hold = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL hold_release_ready got=%b exp=01", req_ready); end
    step();
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h0000_00A3) begin
      failures++; $display("FAIL hold_release_write got=%b/%0d/%h exp=1/3/a3", rf_wen, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_pend_hit();
    set_req(2'b01, 5'd5, 5'd7, 32'h0000_0055, 32'h0);
    pend_addr = 5'd5;
    #1;
    checks++; if (pend_hit !== 1'b0) begin failures++; $display("FAIL pend_before got=%b exp=0", pend_hit); end
    step();
    checks++; if (rf_wen !== 1'b1 || pend_hit !== 1'b1) begin failures++; $display("FAIL pend_write got=%b/%b exp=1/1", rf_wen, pend_hit); end
    req_valid = 2'b00;
    step();
    checks++; if (pend_hit !== 1'b0) begin failures++; $display("FAIL pend_after got=%b exp=0", pend_hit); end
    set_req(2'b01, 5'd6, 5'd7, 32'h0000_0066, 32'h0);
    step();
    checks++; if (rf_wen !== 1'b1 || pend_hit !== 1'b0) begin failures++; $display("FAIL pend_mismatch got=%b/%b exp=1/0", rf_wen, pend_hit); end
    set_req(2'b01, 5'd0, 5'd7, 32'h0000_0077, 32'h0);
    pend_addr = 5'd0;
    step();
    checks++; if (rf_wen !== 1'b0 || pend_hit !== 1'b0) begin failures++; $display("FAIL pend_zero got=%b/%b exp=0/0", rf_wen, pend_hit); end
  endtask

  task automatic test_reset_midstream();
    set_req(2'b11, 5'd9, 5'd12, 32'h0000_0099, 32'h0000_00CC);
    #1;
    checks++; if (req_ready !== (RR ? 2'b10 : 2'b01)) begin failures++; $display("FAIL mid_ready got=%b", req_ready); end
    step();
    checks++; if (rf_waddr !== (RR ? 5'd12 : 5'd9)) begin failures++; $display("FAIL mid_waddr got=%0d", rf_waddr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      failures++; $display("FAIL mid_reset_out got=%b/%0d/%h exp=0/0/0", rf_wen, rf_waddr, rf_wdata);
    end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL mid_reset_ready got=%b exp=00", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL post_reset_ready got=%b exp=01", req_ready); end
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL post_reset_wen got=%b exp=0", rf_wen); end
    step();
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h0000_0099) begin
      failures++; $display("FAIL post_reset_write got=%b/%0d/%h exp=1/9/99", rf_wen, rf_waddr, rf_wdata);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_priority();
    test_addr_zero();
    test_hold();
    test_pend_hit();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
